// File: rtl/psel_bus_arbiter.sv
// rtl/psel_bus_arbiter.sv - round-robin requester arbiter and SETUP/ACCESS sequencer for a two-target select bus (PSEL_TIMEOUT_EN adds the ACCESS abort)
module psel_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_tgt,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              err,
  output logic [1:0]        pselx,
  output logic              penable,
  output logic [DW-1:0]     pdata,
  input  logic              pready,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [1:0]      pselx_q, pselx_d;
  logic            penable_q, penable_d;
  logic [DW-1:0]   pdata_q, pdata_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic            found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   ptr_next;
  logic            done;

`ifdef PSEL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign pselx   = pselx_q;
  assign penable = penable_q;
  assign pdata   = pdata_q;
  assign busy    = busy_q;

  // Pointer moves one past the winner, wrapping at NREQ, so the winner goes last next round.
  assign ptr_next = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  // Pick the first requester at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  // Bus phase sequencing: IDLE latches a winner, SETUP selects, ACCESS strobes until pready (or abort).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    pdata_d   = pdata_q;
    busy_d    = busy_q;
    gnt_d     = '0;
    done      = 1'b0;
`ifdef PSEL_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = win_idx;
          pselx_d = req_tgt[win_idx] ? 2'b10 : 2'b01;
          pdata_d = req_data[int'(win_idx)*DW +: DW];
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef PSEL_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (pready) begin
          done = 1'b1;
        end
`ifdef PSEL_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // Limit reached on this wait cycle: abort with an error-flagged grant.
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      gnt_d[win_q] = 1'b1;
      pselx_d      = 2'b00;
      penable_d    = 1'b0;
      busy_d       = 1'b0;
      ptr_d        = ptr_next;
      state_d      = IDLE;
    end
  end

  // State and registered outputs; reset returns the bus to idle at once with no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      pselx_q   <= 2'b00;
      penable_q <= 1'b0;
      pdata_q   <= '0;
      busy_q    <= 1'b0;
      gnt_q     <= '0;
`ifdef PSEL_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      pdata_q   <= pdata_d;
      busy_q    <= busy_d;
      gnt_q     <= gnt_d;
`ifdef PSEL_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_psel_bus_arbiter.sv
// tb/tb_psel_bus_arbiter.sv - directed vector bench for psel_bus_arbiter (timeout cases under PSEL_TIMEOUT_EN)
module tb_psel_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_tgt;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        err;
  logic [1:0]  pselx;
  logic        penable;
  logic [7:0]  pdata;
  logic        pready;
  logic        busy;

  int n_chk;
  int n_fail;

  psel_bus_arbiter #(.NREQ(4), .DW(8), .TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_tgt  (req_tgt),
    .req_data (req_data),
    .gnt      (gnt),
    .err      (err),
    .pselx    (pselx),
    .penable  (penable),
    .pdata    (pdata),
    .pready   (pready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  tgt;
    logic [31:0] data;
    int          waits;
    logic        drop;
    logic [3:0]  egnt;
    logic [1:0]  epsel;
    logic [7:0]  edata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  // One complete transfer starting from IDLE; waits = number of pready-low ACCESS cycles.
  task automatic run_xfer(input vec_t v, input string tag);
    @(negedge clk);
    chk(tag, "idle_busy", 32'(busy), 0);
    chk(tag, "idle_psel", 32'(pselx), 0);
    req      = v.req;
    req_tgt  = v.tgt;
    req_data = v.data;
    pready   = 1'b1;
    @(negedge clk);
    chk(tag, "setup_psel", 32'(pselx), 32'(v.epsel));
    chk(tag, "setup_pdata", 32'(pdata), 32'(v.edata));
    chk(tag, "setup_penable", 32'(penable), 0);
    chk(tag, "setup_busy", 32'(busy), 1);
    if (v.drop) begin
      req      = 4'b0000;
      req_data = ~v.data;
      req_tgt  = ~v.tgt;
    end
    pready = 1'b1;
    for (int w = 0; w <= v.waits; w++) begin
      @(negedge clk);
      chk(tag, "access_penable", 32'(penable), 1);
      chk(tag, "access_psel", 32'(pselx), 32'(v.epsel));
      chk(tag, "access_pdata", 32'(pdata), 32'(v.edata));
      chk(tag, "access_gnt", 32'(gnt), 0);
      pready = (w == v.waits);
    end
    @(negedge clk);
    chk(tag, "gnt", 32'(gnt), 32'(v.egnt));
    chk(tag, "err", 32'(err), 0);
    chk(tag, "done_psel", 32'(pselx), 0);
    chk(tag, "done_penable", 32'(penable), 0);
    chk(tag, "done_busy", 32'(busy), 0);
    chk(tag, "done_pdata_hold", 32'(pdata), 32'(v.edata));
    req    = 4'b0000;
    pready = 1'b0;
    @(negedge clk);
    chk(tag, "gnt_one_cycle", 32'(gnt), 0);
    chk(tag, "stay_idle", 32'(busy), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_gnt[5];
    logic [1:0] rr_psel[5];
    logic [7:0] rr_data[5];
    int         rr_cyc[5];
    logic [3:0] exp_gnt[5];
    logic [1:0] exp_psel[5];
    logic [7:0] exp_data[5];
    int         ng;
    int         ns;
    vec_t       vr;

    n_chk    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    req_tgt  = '0;
    req_data = '0;
    pready   = 1'b0;

    //              req      tgt      data          waits drop egnt     psel   edata
    vecs[0] = '{4'b0001, 4'b0000, 32'h000000AB, 0, 1'b0, 4'b0001, 2'b01, 8'hAB};
    vecs[1] = '{4'b0101, 4'b0100, 32'h335C2211, 1, 1'b0, 4'b0100, 2'b10, 8'h5C};
    vecs[2] = '{4'b0011, 4'b0010, 32'h44332217, 0, 1'b1, 4'b0001, 2'b01, 8'h17};
    vecs[3] = '{4'b1010, 4'b1000, 32'h9F00C600, 5, 1'b0, 4'b0010, 2'b01, 8'hC6};
    vecs[4] = '{4'b1001, 4'b1000, 32'hE1000077, 0, 1'b0, 4'b1000, 2'b10, 8'hE1};
    vecs[5] = '{4'b1000, 4'b0000, 32'h3C000000, 2, 1'b1, 4'b1000, 2'b01, 8'h3C};
    vecs[6] = '{4'b0110, 4'b0100, 32'h0055AA00, 0, 1'b0, 4'b0010, 2'b01, 8'hAA};
    vecs[7] = '{4'b1111, 4'b1111, 32'h04030201, 0, 1'b0, 4'b0100, 2'b10, 8'h03};

    repeat (2) @(negedge clk);
    chk("reset", "pselx", 32'(pselx), 0);
    chk("reset", "penable", 32'(penable), 0);
    chk("reset", "pdata", 32'(pdata), 0);
    chk("reset", "gnt", 32'(gnt), 0);
    chk("reset", "err", 32'(err), 0);
    chk("reset", "busy", 32'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i], $sformatf("vec%0d", i));
    end

    // Round robin with all four requests held and pready always high.
    pulse_reset();
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100; exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    exp_psel[0] = 2'b01; exp_psel[1] = 2'b10; exp_psel[2] = 2'b01; exp_psel[3] = 2'b10; exp_psel[4] = 2'b01;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44; exp_data[4] = 8'h11;
    for (int i = 0; i < 5; i++) begin
      rr_gnt[i] = '0; rr_psel[i] = '0; rr_data[i] = '0; rr_cyc[i] = 0;
    end
    ng = 0;
    ns = 0;
    req      = 4'b1111;
    req_tgt  = 4'b1010;
    req_data = 32'h44332211;
    pready   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pselx != 2'b00 && !penable && ns < 5) begin
        rr_psel[ns] = pselx;
        rr_data[ns] = pdata;
        ns++;
      end
      if (gnt != 4'b0000) begin
        rr_gnt[ng] = gnt;
        rr_cyc[ng] = c;
        ng++;
        if (ng == 5) begin
          req = 4'b0000;
          break;
        end
      end
    end
    pready = 1'b0;
    chk("rr", "grant_count", 32'(ng), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr%0d", i), "gnt", 32'(rr_gnt[i]), 32'(exp_gnt[i]));
      chk($sformatf("rr%0d", i), "psel", 32'(rr_psel[i]), 32'(exp_psel[i]));
      chk($sformatf("rr%0d", i), "pdata", 32'(rr_data[i]), 32'(exp_data[i]));
      if (i > 0) chk($sformatf("rr%0d", i), "spacing", 32'(rr_cyc[i] - rr_cyc[i-1]), 3);
    end
    @(negedge clk);
    chk("rr", "idle_after", 32'(busy), 0);

    // Reset asserted in the middle of a wait-stated ACCESS.
    req      = 4'b0100;
    req_tgt  = 4'b0000;
    req_data = 32'h00EE0000;
    pready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid", "in_access", 32'(penable), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid", "pselx", 32'(pselx), 0);
    chk("rst_mid", "penable", 32'(penable), 0);
    chk("rst_mid", "busy", 32'(busy), 0);
    chk("rst_mid", "gnt", 32'(gnt), 0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_mid", "no_gnt", 32'(gnt), 0);
    end
    vr = '{4'b0101, 4'b0000, 32'h00220011, 0, 1'b0, 4'b0001, 2'b01, 8'h11};
    run_xfer(vr, "ptr_after_rst");

`ifdef PSEL_TIMEOUT_EN
    begin
      int   pen;
      logic got;
      logic [3:0] g;
      logic e;
      logic [1:0] ps;
      pulse_reset();
      req      = 4'b0011;
      req_tgt  = 4'b0000;
      req_data = 32'h00006655;
      pready   = 1'b0;
      pen = 0; got = 1'b0; g = '0; e = 1'b0; ps = 2'b11;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (penable) pen++;
        if (gnt != 4'b0000) begin
          got = 1'b1; g = gnt; e = err; ps = pselx;
          req = 4'b0010;
          break;
        end
      end
      chk("timeout", "seen", 32'(got), 1);
      chk("timeout", "access_cycles", 32'(pen), 16);
      chk("timeout", "gnt", 32'(g), 32'b0001);
      chk("timeout", "err", 32'(e), 1);
      chk("timeout", "psel", 32'(ps), 0);
      pen = 0; got = 1'b0; g = '0; e = 1'b1;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (penable) begin
          pen++;
          if (pen == 16) pready = 1'b1;
        end
        if (gnt != 4'b0000) begin
          got = 1'b1; g = gnt; e = err;
          req = 4'b0000;
          break;
        end
      end
      pready = 1'b0;
      chk("limit_ready", "seen", 32'(got), 1);
      chk("limit_ready", "access_cycles", 32'(pen), 16);
      chk("limit_ready", "gnt", 32'(g), 32'b0010);
      chk("limit_ready", "err", 32'(e), 0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
